// File: rtl/i2c_pkg.sv
// Shared constants, types and helpers for the I2C bus front-end.
package i2c_pkg;

    localparam logic I2C_IDLE_LEVEL = 1'b1;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } i2c_edge_t;

    function automatic int filt_cnt_w(input int filter_len);
        return $clog2(filter_len + 1);
    endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Per-line front-end: N-flop synchronizer, persistence glitch filter and
// edge detection on the filtered level.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      i_pin,
    output i2c_edge_t o_edge
);

    localparam int              CW       = filt_cnt_w(FILTER_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_f;
    logic                   r_d;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    // The level must disagree with r_f for FILTER_LEN consecutive cycles to flip it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_f   <= I2C_IDLE_LEVEL;
            r_d   <= I2C_IDLE_LEVEL;
        end else begin
            r_d <= r_f;
            if (w_sync == r_f) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_f   <= ~r_f;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_edge.level = r_f;
    assign o_edge.rise  = r_f & ~r_d;
    assign o_edge.fall  = ~r_f & r_d;

endmodule

// File: rtl/i2c_bus_conditioner.sv
// I2C pin conditioner: filtered SCL/SDA, edge pulses, START/STOP detection,
// bus-busy tracking and an optional SCL-stuck-low timeout.
module i2c_bus_conditioner
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic scl_timeout
);

    i2c_edge_t w_scl;
    i2c_edge_t w_sda;
    logic      w_scl_stable;
    logic      w_timeout;
    logic      r_busy;

    i2c_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_scl (
        .clk    (clk),
        .reset_n(reset_n),
        .i_pin  (scl_in),
        .o_edge (w_scl)
    );

    i2c_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_sda (
        .clk    (clk),
        .reset_n(reset_n),
        .i_pin  (sda_in),
        .o_edge (w_sda)
    );

    // High only when SCL is high now and was high last cycle (no SCL edge this cycle).
    assign w_scl_stable = w_scl.level & ~w_scl.rise;

    assign scl_f     = w_scl.level;
    assign sda_f     = w_sda.level;
    assign scl_rise  = w_scl.rise;
    assign scl_fall  = w_scl.fall;
    assign start_det = w_sda.fall & w_scl_stable;
    assign stop_det  = w_sda.rise & w_scl_stable;
    assign bus_busy  = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
        end else if (start_det) begin
            r_busy <= 1'b1;
        end else if (stop_det || w_timeout) begin
            r_busy <= 1'b0;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
            localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT_CYCLES);

            logic [TW-1:0] r_to_cnt;
            logic          r_to;
            logic          w_inc;

            // Saturating at TO_SAT keeps the pulse single until SCL is released.
            assign w_inc = r_busy & ~w_scl.level & (r_to_cnt != TO_SAT);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_to_cnt <= '0;
                    r_to     <= 1'b0;
                end else begin
                    r_to <= w_inc & (r_to_cnt == TO_LAST);
                    if (w_scl.level) begin
                        r_to_cnt <= '0;
                    end else if (w_inc) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end else if (r_to_cnt != TO_SAT) begin
                        r_to_cnt <= '0;
                    end
                end
            end

            assign w_timeout = r_to;
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign scl_timeout = w_timeout;

endmodule
